lift_platform_ctrl: RTL and testbench
=====================================

Name: lift_platform_ctrl

Overview:
- Sequences the moving lift platform in the level from pressure-plate contact events.
- Arbitrates four contact sources: fire/water character on plate A/B. Any contact raises the platform; releasing all contacts returns it after a dwell.
- Advances position once per video frame; feeds platform_y to the sprite renderer and collision logic.

Parameters:
Y_TOP, 240, raised platform y (pixels, top-edge row)
Y_BOTTOM, 300, rest platform y; Y_TOP < Y_BOTTOM < 1024
STEP, 1, pixels moved per frame tick (1..15)
HOLD_FRAMES, 30, frame ticks the platform dwells at top after all plates released

Ports:
Clk  in  1  system clock
Reset  in  1  reset
frame_clk  in  1  vsync-rate frame strobe, level signal, synchronous to Clk
plate_a_fire  in  1  fireboy standing on plate A (from per-plate detector)
plate_a_water  in  1  watergirl on plate A
plate_b_fire  in  1  fireboy on plate B
plate_b_water  in  1  watergirl on plate B
block_below  in  1  a character occupies the column beneath the platform
platform_y  out  10  current platform y
moving  out  1  platform changed position on the last tick
at_top  out  1  platform_y == Y_TOP
plate_a_lit  out  1  plate A pressed (registered)
plate_b_lit  out  1  plate B pressed (registered)

Behaviour:
- Reset: synchronous, active-high, clock Clk. Sets state=IDLE, platform_y=Y_BOTTOM, hold_cnt=0, frame_q=0, moving=0, at_top=0, plate_a_lit=0, plate_b_lit=0. Reset asserted mid-motion returns platform_y to Y_BOTTOM on the next edge.
- Tick: frame_q <= frame_clk every Clk; tick = frame_clk & ~frame_q. This is one Clk cycle per frame rising edge. Position changes only in a tick cycle, registered on that edge.
- pressed = OR of all four plate inputs. plate_x_lit <= OR of that plate's two inputs, 1-cycle latency.
- States:
  - IDLE:
    - platform_y held at Y_BOTTOM.
    - pressed -> RISING. No movement in the transition cycle, even on a tick.
  - RISING:
    - !pressed -> LOWERING. Release wins over a same-cycle tick: no movement that cycle.
    - Else, on tick: platform_y <= max(platform_y - STEP, Y_TOP). Compute in 11 bits; no underflow or wrap.
    - When the new value equals Y_TOP: -> TOP, hold_cnt <= HOLD_FRAMES.
  - TOP:
    - pressed: hold_cnt <= HOLD_FRAMES (reload every cycle).
    - !pressed and tick: hold_cnt decrements.
    - hold_cnt==0 and !pressed: -> LOWERING. The transition is taken the cycle after hold_cnt reaches 0, without waiting for a tick.
  - LOWERING:
    - pressed -> RISING. Same cycle: no movement.
    - Else, on tick with !block_below: platform_y <= min(platform_y + STEP, Y_BOTTOM).
    - On tick with block_below: position held (crush guard).
    - When the new value equals Y_BOTTOM: -> IDLE.
- moving: updated on every tick. 1 if platform_y changed on that tick, else 0. Holds its value between ticks.
- at_top: combinational compare of registered platform_y; no extra latency.
- Non-multiple spans: with STEP not dividing the span, the final step saturates exactly to Y_TOP/Y_BOTTOM. The value never passes either limit.

Test Plan:
- Reset, then idle 10 frames -> platform_y=300, at_top=0, moving=0, lit outputs 0.
- Hold plate_a_fire for 70 ticks -> y decreases by 1 per tick (299, 298, ...), reaches 240 on tick 60. Then at_top=1, moving=0 on tick 61, plate_a_lit=1.
- From top, release all plates -> y stays 240 for 30 ticks, then increments 1/tick and reaches 300 after 60 further ticks. State returns to IDLE.
- Press plate_b_water for 20 ticks (y=280), then release -> no movement in the release cycle. Next ticks give 281, 282, ... Re-press at y=290 -> RISING, next tick 289.
- Lowering at y=270 with block_below=1 for 5 ticks -> y stays 270, moving=0. Deassert -> 271 on the next tick.
- STEP=4, Y_TOP=241, Y_BOTTOM=300, hold plate -> y sequence 296..244, then saturates to 241 with no wrap. Assert Reset mid-rise -> y=300 next edge.

Source files
------------

// File: rtl/lift_platform_ctrl.sv
// Lift platform sequencer: raises the platform while any pressure plate is held,
// dwells at the top after release, then lowers it, moving once per frame tick.
module lift_platform_ctrl #(
    parameter int Y_TOP       = 240,
    parameter int Y_BOTTOM    = 300,
    parameter int STEP        = 1,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       plate_a_fire,
    input  logic       plate_a_water,
    input  logic       plate_b_fire,
    input  logic       plate_b_water,
    input  logic       block_below,
    output logic [9:0] platform_y,
    output logic       moving,
    output logic       at_top,
    output logic       plate_a_lit,
    output logic       plate_b_lit
);

    localparam int HW = $clog2(HOLD_FRAMES + 2);
    localparam logic [10:0] YT11   = 11'(Y_TOP);
    localparam logic [10:0] YB11   = 11'(Y_BOTTOM);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, RISING, TOP, LOWERING} state_t;

    state_t        state, state_n;
    logic [9:0]    y_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          moving_n;
    logic          frame_q;
    logic          tick;
    logic          pressed;
    logic [10:0]   y11;
    logic [10:0]   y_toward_top;
    logic [10:0]   y_toward_bottom;

    assign tick    = frame_clk & ~frame_q;
    assign pressed = plate_a_fire | plate_a_water | plate_b_fire | plate_b_water;
    assign at_top  = (platform_y == YT11[9:0]);

    // Saturating 11-bit step so a step larger than the remaining span clamps to the limit
    assign y11             = {1'b0, platform_y};
    assign y_toward_top    = (y11 >= YT11 + STEP11) ? (y11 - STEP11) : YT11;
    assign y_toward_bottom = (y11 + STEP11 <= YB11) ? (y11 + STEP11) : YB11;

    always_comb begin
        state_n  = state;
        y_n      = platform_y;
        hold_n   = hold_cnt;
        moving_n = moving;
        case (state)
            IDLE: begin
                y_n = YB11[9:0];
                if (pressed) state_n = RISING;
            end
            RISING: begin
                if (!pressed) begin
                    state_n = LOWERING;
                end else if (tick) begin
                    y_n = y_toward_top[9:0];
                    if (y_toward_top == YT11) begin
                        state_n = TOP;
                        hold_n  = HOLD_LOAD;
                    end
                end
            end
            TOP: begin
                if (pressed) begin
                    hold_n = HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    state_n = LOWERING;
                end else if (tick) begin
                    hold_n = hold_cnt - 1'b1;
                end
            end
            LOWERING: begin
                if (pressed) begin
                    state_n = RISING;
                end else if (tick && !block_below) begin
                    y_n = y_toward_bottom[9:0];
                    if (y_toward_bottom == YB11) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (tick) moving_n = (y_n != platform_y);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            platform_y  <= YB11[9:0];
            hold_cnt    <= '0;
            frame_q     <= 1'b0;
            moving      <= 1'b0;
            plate_a_lit <= 1'b0;
            plate_b_lit <= 1'b0;
        end else begin
            state       <= state_n;
            platform_y  <= y_n;
            hold_cnt    <= hold_n;
            frame_q     <= frame_clk;
            moving      <= moving_n;
            plate_a_lit <= plate_a_fire | plate_a_water;
            plate_b_lit <= plate_b_fire | plate_b_water;
        end
    end

endmodule

// File: tb/tb_lift_platform_ctrl.sv
// Directed bench for lift_platform_ctrl: expected positions are queued per frame tick
// and compared after the tick edge; a second instance covers a coarse step.
module tb_lift_platform_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, Reset2;
    logic       frame_clk;
    logic       plate_a_fire, plate_a_water, plate_b_fire, plate_b_water;
    logic       block_below;
    logic       plate2;
    logic [9:0] platform_y, platform_y2;
    logic       moving, moving2, at_top, at_top2;
    logic       plate_a_lit, plate_b_lit, plate_a_lit2, plate_b_lit2;

    int compared   = 0;
    int mismatched = 0;
    int expY;

    typedef struct {
        int    sel;
        string tag;
        int    y;
        int    mov;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    lift_platform_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .plate_a_fire(plate_a_fire), .plate_a_water(plate_a_water),
        .plate_b_fire(plate_b_fire), .plate_b_water(plate_b_water),
        .block_below(block_below), .platform_y(platform_y), .moving(moving),
        .at_top(at_top), .plate_a_lit(plate_a_lit), .plate_b_lit(plate_b_lit)
    );

    lift_platform_ctrl #(.Y_TOP(241), .Y_BOTTOM(300), .STEP(4), .HOLD_FRAMES(30)) dut2 (
        .Clk(Clk), .Reset(Reset2), .frame_clk(frame_clk),
        .plate_a_fire(plate2), .plate_a_water(1'b0),
        .plate_b_fire(1'b0), .plate_b_water(1'b0),
        .block_below(1'b0), .platform_y(platform_y2), .moving(moving2),
        .at_top(at_top2), .plate_a_lit(plate_a_lit2), .plate_b_lit(plate_b_lit2)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the selected instance
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                checkVal({e.tag, "_y"}, 32'(platform_y), e.y);
                checkVal({e.tag, "_moving"}, 32'(moving), e.mov);
            end else begin
                checkVal({e.tag, "_y"}, 32'(platform_y2), e.y);
                checkVal({e.tag, "_moving"}, 32'(moving2), e.mov);
            end
        end
    endtask

    // Queue the expectation, raise the frame strobe in this cycle, check after the edge
    task automatic applyStimulus(input int sel, input string tag, input int y, input int mov);
        exp_t e;
        e.sel = sel; e.tag = tag; e.y = y; e.mov = mov;
        sb.push_back(e);
        frame_clk = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput();
        @(negedge Clk) frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        Reset = 1'b1; Reset2 = 1'b1; frame_clk = 1'b0;
        plate_a_fire = 0; plate_a_water = 0; plate_b_fire = 0; plate_b_water = 0;
        block_below = 0; plate2 = 0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0; Reset2 = 1'b0;
        #1;
        checkVal("rst_y", 32'(platform_y), 300);
        checkVal("rst_at_top", 32'(at_top), 0);
        checkVal("rst_moving", 32'(moving), 0);
        checkVal("rst_a_lit", 32'(plate_a_lit), 0);
        checkVal("rst_b_lit", 32'(plate_b_lit), 0);
        @(negedge Clk);

        for (int i = 0; i < 10; i++) applyStimulus(0, "idle", 300, 0);

        // Rise from bottom to top on plate A
        plate_a_fire = 1'b1;
        @(negedge Clk);
        expY = 300;
        for (int i = 1; i <= 70; i++) begin
            if (i <= 60) begin
                expY = expY - 1;
                applyStimulus(0, "rise", expY, 1);
            end else begin
                applyStimulus(0, "top_held", 240, 0);
            end
        end
        checkVal("top_at_top", 32'(at_top), 1);
        checkVal("top_a_lit", 32'(plate_a_lit), 1);

        // Release: 30-frame dwell then descend to bottom
        plate_a_fire = 1'b0;
        @(negedge Clk);
        for (int i = 1; i <= 30; i++) applyStimulus(0, "dwell", 240, 0);
        for (int i = 1; i <= 60; i++) begin
            expY = expY + 1;
            applyStimulus(0, "lower", expY, 1);
        end
        checkVal("bottom_at_top", 32'(at_top), 0);
        applyStimulus(0, "idle_again", 300, 0);

        // Partial rise on plate B, release coincident with a tick
        plate_b_water = 1'b1;
        @(negedge Clk);
        for (int i = 1; i <= 20; i++) begin
            expY = expY - 1;
            applyStimulus(0, "rise_b", expY, 1);
        end
        checkVal("b_lit", 32'(plate_b_lit), 1);
        plate_b_water = 1'b0;
        applyStimulus(0, "release_tick", 280, 0);
        for (int i = 1; i <= 10; i++) begin
            expY = expY + 1;
            applyStimulus(0, "lower_b", expY, 1);
        end
        plate_b_water = 1'b1;
        applyStimulus(0, "repress_tick", 290, 0);
        for (int i = 1; i <= 20; i++) begin
            expY = expY - 1;
            applyStimulus(0, "rerise", expY, 1);
        end

        // Crush guard at y=270
        plate_b_water = 1'b0;
        @(negedge Clk);
        block_below = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, "blocked", 270, 0);
        block_below = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            expY = expY + 1;
            applyStimulus(0, "unblocked", expY, 1);
        end

        // Reset in the middle of a rise
        plate_a_water = 1'b1;
        @(negedge Clk);
        for (int i = 1; i <= 3; i++) begin
            expY = expY - 1;
            applyStimulus(0, "rise_pre_rst", expY, 1);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkVal("midrst_y", 32'(platform_y), 300);
        checkVal("midrst_moving", 32'(moving), 0);
        checkVal("midrst_a_lit", 32'(plate_a_lit), 0);
        @(negedge Clk);
        Reset = 1'b0; plate_a_water = 1'b0;
        @(negedge Clk);

        // Coarse step instance: non-multiple span saturates at 241
        plate2 = 1'b1;
        @(negedge Clk);
        expY = 300;
        for (int i = 1; i <= 15; i++) begin
            expY = (expY - 4 < 241) ? 241 : expY - 4;
            applyStimulus(1, "step4", expY, 1);
        end
        checkVal("step4_at_top", 32'(at_top2), 1);
        applyStimulus(1, "step4_top", 241, 0);

        Reset2 = 1'b1;
        @(negedge Clk);
        Reset2 = 1'b0;
        @(negedge Clk);
        applyStimulus(1, "step4_again", 296, 1);
        applyStimulus(1, "step4_again", 292, 1);
        Reset2 = 1'b1;
        @(posedge Clk);
        #1;
        checkVal("step4_midrst_y", 32'(platform_y2), 300);
        @(negedge Clk);
        Reset2 = 1'b0; plate2 = 1'b0;
        repeat (2) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
